spi_req_arbiter: RTL

- Shares one SPI master (single-lane/dual-lane command/address/data engine, cmd bit7 = read) between REQ_NUM requesters, e.g. register-access host and calibration sequencer.
- Round-robin grant.
- Launches each transaction with a one-cycle enable and tracks it via the master's busy flag.
- Routes write-data requests and read-data beats to the granted requester, then reports completion and beat-count errors.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/spi_req_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI request arbiter: FSM state encodings,
// command field positions and the beat-count helper.
package spi_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_XFER      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  // Command layout understood by the master: bit 7 selects read,
  // bits [4:0] hold (beat count - 1).
  localparam int CMD_RD_BIT  = 7;
  localparam int CMD_LEN_MSB = 4;

  // Beat counter width; the counter saturates at its all-ones value.
  localparam int BEAT_W = 6;
  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  // Number of data beats a command is expected to move.
  function automatic logic [BEAT_W-1:0] exp_beats(input logic [CMD_LEN_MSB:0] len);
    return BEAT_W'(len) + BEAT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first asserted request at
// or after ptr_i (wrapping) as a one-hot grant and a binary index.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int REQ_NUM = 2,
  parameter int IDX_W   = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [REQ_NUM-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic             found;
  logic [IDX_W-1:0] slot;

  // Scan slots in priority order starting from the pointer; first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    slot  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      slot = IDX_W'((int'(ptr_i) + i) % REQ_NUM);
      if (!found && req_i[slot]) begin
        found       = 1'b1;
        gnt_o[slot] = 1'b1;
        idx_o       = slot;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master between REQ_NUM requesters with round-robin grant.
// A transaction is launched with a one-cycle spi_en_o, tracked through the
// master's busy flag, and closed with done_o (plus err_o when the number of
// data beats differs from cmd[4:0]+1).
// Optional: define SPI_ARB_TIMEOUT_EN to add a watchdog that forces
// completion with err_o after TIMEOUT_CYC cycles in ST_WAIT_BUSY/ST_XFER.
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter int REQ_NUM     = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int CMD_WIDTH   = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [REQ_NUM-1:0]            req_i,
  input  logic [REQ_NUM*CMD_WIDTH-1:0]  req_cmd_i,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_wr_data_i,
  output logic [REQ_NUM-1:0]            gnt_o,
  output logic [REQ_NUM-1:0]            req_wr_seq_o,
  output logic [REQ_NUM-1:0]            req_rd_vld_o,
  output logic [DATA_WIDTH-1:0]         req_rd_data_o,
  output logic [REQ_NUM-1:0]            done_o,
  output logic [REQ_NUM-1:0]            err_o,
  output logic                          spi_en_o,
  output logic [CMD_WIDTH-1:0]          spi_cmd_o,
  output logic [ADDR_WIDTH-1:0]         spi_addr_o,
  output logic [DATA_WIDTH-1:0]         spi_wr_data_o,
  input  logic                          spi_wr_seq_i,
  input  logic                          spi_rd_vld_i,
  input  logic [DATA_WIDTH-1:0]         spi_rd_data_i,
  input  logic                          spi_busy_i
);

  localparam int IDX_W = $clog2(REQ_NUM);

  if (REQ_NUM < 2 || REQ_NUM > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_param_check
    $error("spi_req_arbiter: REQ_NUM or TIMEOUT_CYC out of range");
  end

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [REQ_NUM-1:0]    gnt_q, gnt_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  en_q, en_d;
  logic [REQ_NUM-1:0]    rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [REQ_NUM-1:0]    arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  in_xfer;
  logic                  in_done;
  logic                  strobe;
  logic                  beat_err;
  logic                  timeout_hit;
  logic                  timeout_err;

  rr_arbiter #(
    .REQ_NUM (REQ_NUM),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign in_xfer  = (state_q == ST_XFER);
  assign in_done  = (state_q == ST_DONE);
  assign strobe   = in_xfer && (spi_wr_seq_i || spi_rd_vld_i);
  assign beat_err = (beat_q != exp_beats(cmd_q[CMD_LEN_MSB:0]));

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] to_q, to_d;
  logic        to_err_q, to_err_d;

  assign timeout_hit = ((state_q == ST_WAIT_BUSY) || in_xfer) && (to_q == 16'(TIMEOUT_CYC - 1));
  assign timeout_err = to_err_q;

  // Watchdog: cleared at launch, counts every cycle spent waiting on the master.
  always_comb begin
    to_d     = to_q;
    to_err_d = to_err_q;
    if (state_q == ST_LAUNCH) begin
      to_d     = '0;
      to_err_d = 1'b0;
    end else if ((state_q == ST_WAIT_BUSY) || in_xfer) begin
      to_d = to_q + 16'd1;
      if (timeout_hit) to_err_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_q     <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_q     <= to_d;
      to_err_q <= to_err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Transaction FSM. spi_en_o is registered out of ST_LAUNCH, so the master
  // sees it two cycles after the request is accepted in ST_IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    en_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_i && !spi_busy_i) begin
          idx_d   = arb_idx;
          gnt_d   = arb_gnt;
          cmd_d   = req_cmd_i[arb_idx*CMD_WIDTH +: CMD_WIDTH];
          addr_d  = req_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
          beat_d  = '0;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        en_d    = 1'b1;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (timeout_hit)     state_d = ST_DONE;
        else if (spi_busy_i) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (strobe && (beat_q != BEAT_MAX)) beat_d = beat_q + BEAT_W'(1);
        if (timeout_hit || !spi_busy_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        gnt_d   = '0;
        ptr_d   = (idx_q == IDX_W'(REQ_NUM - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read beats are registered so data and its valid reach the requester together.
  always_comb begin
    rd_vld_d  = '0;
    rd_data_d = rd_data_q;
    if (in_xfer && spi_rd_vld_i) begin
      rd_vld_d  = gnt_q;
      rd_data_d = spi_rd_data_i;
    end
  end

  // State and datapath registers; reset abandons any transaction silently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      beat_q    <= '0;
      en_q      <= 1'b0;
      rd_vld_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      en_q      <= en_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign spi_en_o      = en_q;
  assign spi_cmd_o     = (|gnt_q) ? cmd_q : '0;
  assign spi_addr_o    = (|gnt_q) ? addr_q : '0;
  assign spi_wr_data_o = (|gnt_q) ? req_wr_data_i[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign req_wr_seq_o  = (in_xfer && spi_wr_seq_i) ? gnt_q : '0;
  assign req_rd_vld_o  = rd_vld_q;
  assign req_rd_data_o = rd_data_q;
  assign done_o        = in_done ? gnt_q : '0;
  assign err_o         = (in_done && (beat_err || timeout_err)) ? gnt_q : '0;

endmodule
